// File: rtl/aes_pkg.sv
// Shared AES definitions: controller state type, round constants and GF(2^8) S-box helpers,
// kept here so the encryptor can reuse the same tables.
package aes_pkg;

    typedef enum logic [2:0] {IDLE, KEYEXP, READY, DECRYPT, OUTPUT} aes_state_e;

    function automatic logic [7:0] rcon(input logic [3:0] round);
        case (round)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse computed as a^254 by an addition chain; zero maps to zero as the S-box needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] a7;
        logic [7:0] t;
        t  = gf_mul(gf_mul(a, a), a);
        a7 = gf_mul(gf_mul(t, t), a);
        t  = gf_mul(gf_mul(a7, a7), a);
        t  = gf_mul(t, t);
        t  = gf_mul(t, t);
        t  = gf_mul(t, t);
        t  = gf_mul(t, a7);
        return gf_mul(t, t);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        return gf_inv({y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [3:0] rk_index(input logic [3:0] i);
        return (i > 4'd10) ? 4'd10 : i;
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey and,
// except on the last round, InvMixColumns.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] round_key_i,
    input  logic         last_round_i,
    output logic [127:0] next_state_o
);

    logic [127:0] subbed;
    logic [127:0] added;
    logic [127:0] mixed;

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {gf_mul(8'h0e, a0) ^ gf_mul(8'h0b, a1) ^ gf_mul(8'h0d, a2) ^ gf_mul(8'h09, a3),
                gf_mul(8'h09, a0) ^ gf_mul(8'h0e, a1) ^ gf_mul(8'h0b, a2) ^ gf_mul(8'h0d, a3),
                gf_mul(8'h0d, a0) ^ gf_mul(8'h09, a1) ^ gf_mul(8'h0e, a2) ^ gf_mul(8'h0b, a3),
                gf_mul(8'h0b, a0) ^ gf_mul(8'h0d, a1) ^ gf_mul(8'h09, a2) ^ gf_mul(8'h0e, a3)};
    endfunction

    // Byte r+4c is row r, column c; row r is rotated right by r columns.
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign subbed[127-8*(r+4*c) -: 8] = inv_sbox(state_i[127-8*(r+4*((c+4-r)%4)) -: 8]);
        end
        assign mixed[127-32*c -: 32] = inv_mix_col(added[127-32*c -: 32]);
    end

    assign added        = subbed ^ round_key_i;
    assign next_state_o = last_round_i ? added : mixed;

endmodule

// File: rtl/aes128_decrypt.sv
// AES-128 decryptor: expands the key forward into an 11-entry round-key file, one key per
// cycle, then runs one inverse round per cycle for a 12-cycle block time.
module aes128_decrypt
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rstn,
    input  logic         en,
    input  logic [127:0] key_in,
    input  logic         data_in_valid,
    input  logic [127:0] data_in,
    output logic         rk_ready,
    output logic         busy,
    output logic         data_out_valid,
    output logic [127:0] data_out
);

    aes_state_e   state_q, state_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] rk_q [0:10];
    logic [127:0] blk_q, blk_d;
    logic [127:0] dout_q, dout_d;
    logic         dvalid_q, dvalid_d;
    logic         loadKey;
    logic [127:0] prevKey, nextKey, roundKey, invRoundOut;
    logic [31:0]  temp;

    always_ff @(posedge clk) begin
        if (rstn) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Accepting a block in READY takes priority over a re-key request.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en) state_d = KEYEXP;
            KEYEXP:  if (round_q == 4'd10) state_d = READY;
            READY:   if (data_in_valid) state_d = DECRYPT;
                     else if (en)       state_d = KEYEXP;
            DECRYPT: if (round_q == 4'd0) state_d = OUTPUT;
            OUTPUT:  state_d = READY;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        rk_ready = 1'b0;
        case (state_q)
            KEYEXP:  busy = 1'b1;
            READY:   rk_ready = 1'b1;
            DECRYPT: begin busy = 1'b1; rk_ready = 1'b1; end
            OUTPUT:  rk_ready = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        prevKey  = rk_q[rk_index(round_q - 4'd1)];
        roundKey = rk_q[rk_index(round_q)];
        temp     = sub_word({prevKey[23:0], prevKey[31:24]}) ^ {rcon(round_q), 24'h0};
        nextKey[127:96] = prevKey[127:96] ^ temp;
        nextKey[95:64]  = prevKey[95:64]  ^ nextKey[127:96];
        nextKey[63:32]  = prevKey[63:32]  ^ nextKey[95:64];
        nextKey[31:0]   = prevKey[31:0]   ^ nextKey[63:32];
    end

    aes_inv_round u_inv_round (
        .state_i      (blk_q),
        .round_key_i  (roundKey),
        .last_round_i (round_q == 4'd0),
        .next_state_o (invRoundOut)
    );

    always_comb begin
        loadKey  = en && ((state_q == IDLE) || (state_q == READY && !data_in_valid));
        round_d  = round_q;
        blk_d    = blk_q;
        dout_d   = dout_q;
        dvalid_d = 1'b0;
        case (state_q)
            IDLE:    if (en) round_d = 4'd1;
            KEYEXP:  round_d = (round_q == 4'd10) ? 4'd0 : round_q + 4'd1;
            READY: begin
                if (data_in_valid) begin
                    blk_d   = data_in ^ rk_q[10];
                    round_d = 4'd9;
                end else if (en) begin
                    round_d = 4'd1;
                end
            end
            DECRYPT: begin
                blk_d   = invRoundOut;
                round_d = (round_q == 4'd0) ? 4'd0 : round_q - 4'd1;
            end
            OUTPUT: begin
                dout_d   = blk_q;
                dvalid_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Key file and cipher state are never observable before a full expansion, so no reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            blk_q <= blk_d;
            if (loadKey)                rk_q[0] <= key_in;
            else if (state_q == KEYEXP) rk_q[rk_index(round_q)] <= nextKey;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            round_q  <= 4'd0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
        end else begin
            round_q  <= round_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
        end
    end

    assign data_out       = dout_q;
    assign data_out_valid = dvalid_q;

endmodule

// File: tb/tb_aes128_decrypt.sv
// Scoreboard bench for aes128_decrypt using the FIPS-197 C.1 and Appendix B vectors;
// stimulus pushes expected plaintext and due cycle, a negedge monitor pops and compares.
module tb_aes128_decrypt;

    logic         clk = 1'b0;
    logic         rstn, en, data_in_valid;
    logic [127:0] key_in, data_in, data_out;
    logic         rk_ready, busy, data_out_valid;

    typedef struct {
        logic [127:0] pt;
        int           dueCyc;
    } exp_t;

    exp_t expQ[$];
    int   nChecks = 0;
    int   nFails  = 0;
    int   cyc     = 0;

    localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;

    aes128_decrypt dut (
        .clk            (clk),
        .rstn           (rstn),
        .en             (en),
        .key_in         (key_in),
        .data_in_valid  (data_in_valid),
        .data_in        (data_in),
        .rk_ready       (rk_ready),
        .busy           (busy),
        .data_out_valid (data_out_valid),
        .data_out       (data_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic v,
                                 input logic [127:0] k, input logic [127:0] d);
        rstn          = r;
        en            = e;
        data_in_valid = v;
        key_in        = k;
        data_in       = d;
    endtask

    task automatic waitReady(input int startCyc, input string name);
        int n = 0;
        while (rk_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (rk_ready === 1'b1) begin
            checkOutput(name, 128'(cyc), 128'(startCyc + 11));
        end else begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL %s: rk_ready never rose, required at cycle %0d", name, startCyc + 11);
        end
    endtask

    task automatic waitDrain(input string name);
        int n = 0;
        while (expQ.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (expQ.size() != 0) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL %s: %0d outputs outstanding, required 0", name, expQ.size());
            expQ.delete();
        end
    endtask

    always @(negedge clk) begin
        if (data_out_valid === 1'b1) begin
            if (expQ.size() == 0) begin
                nChecks++;
                nFails++;
                $display("[TB] FAIL unexpectedValid: data_out_valid=1 at cycle %0d, required 0", cyc);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("plaintext", data_out, e.pt);
                checkOutput("validCycle", 128'(cyc), 128'(e.dueCyc));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t0;
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
        repeat (3) @(negedge clk);
        checkBit("resetRkReady", rk_ready, 1'b0);
        checkBit("resetBusy", busy, 1'b0);
        checkBit("resetValid", data_out_valid, 1'b0);
        checkOutput("resetDataOut", data_out, '0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);

        // Key expansion with a stray data_in_valid pulse while busy.
        @(negedge clk);
        t0 = cyc;
        applyStimulus(1'b0, 1'b1, 1'b0, KEY1, '0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        checkBit("keyexpBusy", busy, 1'b1);
        checkBit("keyexpRkReady", rk_ready, 1'b0);
        repeat (2) @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b1, '0, CT1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        waitReady(t0, "key1RkReady");

        // Single block with ignored data_in_valid and en while decrypting.
        t0 = cyc;
        applyStimulus(1'b0, 1'b0, 1'b1, '0, CT1);
        expQ.push_back('{PT1, t0 + 12});
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        checkBit("decBusy", busy, 1'b1);
        checkBit("decRkReady", rk_ready, 1'b1);
        repeat (2) @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b1, '0, CT2);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 1'b0, KEY2, '0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        waitDrain("dec1Drain");
        checkBit("postDecBusy", busy, 1'b0);
        checkBit("postDecRkReady", rk_ready, 1'b1);

        // Re-key from READY.
        t0 = cyc;
        applyStimulus(1'b0, 1'b1, 1'b0, KEY2, '0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        checkBit("rekeyRkReadyDrop", rk_ready, 1'b0);
        checkBit("rekeyBusy", busy, 1'b1);
        waitReady(t0, "key2RkReady");

        // Back-to-back blocks; en alongside the first data_in_valid must lose.
        t0 = cyc;
        applyStimulus(1'b0, 1'b1, 1'b1, KEY1, CT2);
        for (int i = 0; i < 3; i++) expQ.push_back('{PT2, t0 + 12 + 12 * i});
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b1, '0, CT2);
        repeat (24) @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        waitDrain("b2bDrain");
        repeat (3) @(negedge clk);
        checkOutput("dataOutHeld", data_out, PT2);

        // Reset when the round counter reaches 4.
        t0 = cyc;
        applyStimulus(1'b0, 1'b0, 1'b1, '0, CT2);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        repeat (5) @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        checkOutput("midResetDataOut", data_out, '0);
        checkBit("midResetValid", data_out_valid, 1'b0);
        checkBit("midResetBusy", busy, 1'b0);
        checkBit("midResetRkReady", rk_ready, 1'b0);

        // Decryption request without a fresh key must be ignored.
        applyStimulus(1'b0, 1'b0, 1'b1, '0, CT2);
        repeat (15) @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        checkBit("noKeyBusy", busy, 1'b0);
        checkBit("noKeyRkReady", rk_ready, 1'b0);

        // Recovery after a new key expansion.
        t0 = cyc;
        applyStimulus(1'b0, 1'b1, 1'b0, KEY1, '0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        waitReady(t0, "key3RkReady");
        t0 = cyc;
        applyStimulus(1'b0, 1'b0, 1'b1, '0, CT1);
        expQ.push_back('{PT1, t0 + 12});
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        waitDrain("recoveryDrain");
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/aes128_decrypt.md
AES128_DECRYPT -- requirements
Module: aes128_decrypt

Interface
REQ-001 The block SHALL have no parameters; AES-128 only (Nk=4, Nr=10).
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rstn  in  1  reset, synchronous and active-high (1 = reset asserted).
REQ-004 en  in  1  start key expansion from key_in.
REQ-005 key_in  in  128  cipher key, sampled on the en acceptance edge only.
REQ-006 data_in_valid  in  1  ciphertext present on data_in.
REQ-007 data_in  in  128  ciphertext block, byte 0 in bits [127:120].
REQ-008 rk_ready  out  1  all 11 round keys valid; decryption may be requested.
REQ-009 busy  out  1  key expansion or decryption in progress.
REQ-010 data_out_valid  out  1  one-cycle strobe; data_out holds plaintext.
REQ-011 data_out  out  128  plaintext, held until the next data_out_valid.

Function
REQ-012 FSM states SHALL be IDLE, KEYEXP, READY, DECRYPT and OUTPUT.
REQ-013 IDLE->KEYEXP on en; key_in is latched as rk[0].
REQ-014 READY->KEYEXP on en when data_in_valid=0; rk_ready SHALL drop on the same edge.
REQ-015 KEYEXP SHALL compute one round key per cycle using the forward FIPS-197 schedule.
REQ-016 KEYEXP SHALL store rk[1]..rk[10] in 10 cycles, then enter READY with rk_ready=1.
REQ-017 In READY, data_in_valid=1 SHALL be accepted: state <= data_in ^ rk[10], round counter <= 9, enter DECRYPT.
REQ-018 If en and data_in_valid are both high in READY, data_in_valid SHALL win and en SHALL be ignored.
REQ-019 In DECRYPT, each cycle SHALL apply one inverse round with rk[counter]: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns.
REQ-020 InvMixColumns SHALL be omitted when counter=0.
REQ-021 Counter SHALL decrement from 9 to 0; after the counter=0 round the FSM SHALL enter OUTPUT.
REQ-022 In OUTPUT, data_out <= state and data_out_valid=1 for exactly one cycle, then READY.
REQ-023 data_out_valid SHALL first be high in the cycle after the 11th edge following the acceptance edge.
REQ-024 Throughput SHALL be one block per 12 cycles.
REQ-025 data_in_valid SHALL be ignored outside READY; there SHALL be no buffering or backpressure beyond busy.
REQ-026 en SHALL be ignored in KEYEXP, DECRYPT and OUTPUT.
REQ-027 busy=1 exactly in KEYEXP and DECRYPT.
REQ-028 rk_ready=1 exactly in READY, DECRYPT and OUTPUT.
REQ-029 Round-key storage SHALL be indexed 0..10; no out-of-range index SHALL be generated.

Reset
REQ-030 rstn=1 at a clock edge SHALL force IDLE, counters=0, rk_ready=0, busy=0, data_out_valid=0 and data_out=0, overriding any other input.
REQ-031 Reset mid-KEYEXP or mid-DECRYPT SHALL abort the operation with no data_out_valid, and SHALL require a new en before decryption.
REQ-032 Round-key and state registers need not be cleared, and SHALL NOT be observable before a completed KEYEXP.

Structure
REQ-033 Shared package aes_pkg SHALL hold the FSM state type, the Rcon table (01..36), and the S-box and inverse S-box functions, so the encryptor can reuse them.
REQ-034 One sub-module, aes_inv_round, SHALL be purely combinational: inputs state, round key, last-round flag; output next state.
REQ-035 Forward key expansion SHALL be inline, using the aes_pkg functions.

Verification
REQ-036 Key 000102030405060708090a0b0c0d0e0f, en pulse -> rk_ready rises 11 cycles later; rk[10]=13111d7fe3944a17f307a78b4d2b30c5.
REQ-037 Same key, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a -> data_out=00112233445566778899aabbccddeeff, valid exactly 12 cycles after the acceptance cycle, one-cycle pulse.
REQ-038 Key 2b7e151628aed2a6abf7158809cf4f3c, ciphertext 3925841d02dc09fbdc118597196a0b32 -> data_out=3243f6a8885a308d313198a2e0370734; back-to-back blocks with data_in_valid held high -> outputs 12 cycles apart.
REQ-039 data_in_valid pulses during KEYEXP and during DECRYPT -> ignored, no extra data_out_valid; en during DECRYPT -> result unchanged.
REQ-040 rstn asserted at DECRYPT counter=4 -> next cycle all outputs 0, no data_out_valid; decryption attempt without en -> ignored.
